// File: rtl/syn_fifo_ext.sv
// Single-clock FIFO with programmable depth, almost-full/empty thresholds,
// occupancy count, overflow/underflow pulses, synchronous clear and optional FWFT read.
module syn_fifo_ext #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 3,
   parameter int AF_LEVEL   = 6,
   parameter int AE_LEVEL   = 1,
   parameter bit FWFT       = 1'b0
) (
   input  logic                  sys_clk,
   input  logic                  sys_rst_n,
   input  logic                  clear,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  wr_req,
   input  logic                  rd_req,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  empty,
   output logic                  full,
   output logic                  almost_empty,
   output logic                  almost_full,
   output logic [ADDR_WIDTH:0]   data_cnt,
   output logic                  overflow,
   output logic                  underflow
);

   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] C_DEPTH = (ADDR_WIDTH+1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0] C_AF    = (ADDR_WIDTH+1)'(AF_LEVEL);
   localparam logic [ADDR_WIDTH:0] C_AE    = (ADDR_WIDTH+1)'(AE_LEVEL);

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [ADDR_WIDTH-1:0] r_wr_ptr;
   logic [ADDR_WIDTH-1:0] r_rd_ptr;
   logic [ADDR_WIDTH:0]   r_count;
   logic                  r_overflow;
   logic                  r_underflow;

   logic w_empty;
   logic w_full;
   logic w_wr_ok;
   logic w_rd_ok;

   // Request semantics: wr_req/rd_req are single-cycle requests, not held handshakes.
   // A request is accepted in the cycle it is high iff the FIFO state (from the
   // registered count) allows it; a refused request is dropped and flagged by a
   // one-cycle overflow/underflow pulse on the following cycle. Clear overrides both.
   assign w_empty = (r_count == '0);
   assign w_full  = (r_count == C_DEPTH);
   assign w_wr_ok = wr_req & ~w_full  & ~clear;
   assign w_rd_ok = rd_req & ~w_empty & ~clear;

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else if (w_wr_ok) begin
         r_mem[r_wr_ptr] <= data_in;
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else if (clear) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         if (w_wr_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_rd_ok) r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_wr_ok, w_rd_ok})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
         r_overflow  <= wr_req & w_full;
         r_underflow <= rd_req & w_empty;
      end
   end

   generate
      if (FWFT) begin : g_fwft
         // Head of queue is always presented; only meaningful while not empty.
         assign data_out = r_mem[r_rd_ptr];
      end else begin : g_std
         logic [DATA_WIDTH-1:0] r_data_out;
         always_ff @(posedge sys_clk or negedge sys_rst_n) begin
            if (!sys_rst_n) begin
               r_data_out <= '0;
            end else if (clear) begin
               r_data_out <= '0;
            end else if (w_rd_ok) begin
               r_data_out <= r_mem[r_rd_ptr];
            end
         end
         assign data_out = r_data_out;
      end
   endgenerate

   assign empty        = w_empty;
   assign full         = w_full;
   assign almost_empty = (r_count <= C_AE);
   assign almost_full  = (r_count >= C_AF);
   assign data_cnt     = r_count;
   assign overflow     = r_overflow;
   assign underflow    = r_underflow;

endmodule

// File: tb/tb_syn_fifo_ext.sv
// Directed bench for syn_fifo_ext: a standard-read instance driven from a vector
// table plus hand sequences, and a FWFT instance exercised by a short sequence.
module tb_syn_fifo_ext;

   localparam int DW = 16;
   localparam int AW = 3;

   logic sys_clk;
   logic sys_rst_n;

   // Standard-read instance
   logic          s_clear, s_wr, s_rd;
   logic [DW-1:0] s_din, s_dout;
   logic          s_empty, s_full, s_ae, s_af, s_ovf, s_udf;
   logic [AW:0]   s_cnt;

   // FWFT instance
   logic          f_clear, f_wr, f_rd;
   logic [DW-1:0] f_din, f_dout;
   logic          f_empty, f_full, f_ae, f_af, f_ovf, f_udf;
   logic [AW:0]   f_cnt;

   int n_vec;
   int n_err;
   logic [DW-1:0] exp_q[$];

   syn_fifo_ext #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AF_LEVEL(6), .AE_LEVEL(1), .FWFT(1'b0)) u_std (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .clear(s_clear), .data_in(s_din),
      .wr_req(s_wr), .rd_req(s_rd), .data_out(s_dout), .empty(s_empty), .full(s_full),
      .almost_empty(s_ae), .almost_full(s_af), .data_cnt(s_cnt),
      .overflow(s_ovf), .underflow(s_udf)
   );

   syn_fifo_ext #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AF_LEVEL(6), .AE_LEVEL(1), .FWFT(1'b1)) u_fwft (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .clear(f_clear), .data_in(f_din),
      .wr_req(f_wr), .rd_req(f_rd), .data_out(f_dout), .empty(f_empty), .full(f_full),
      .almost_empty(f_ae), .almost_full(f_af), .data_cnt(f_cnt),
      .overflow(f_ovf), .underflow(f_udf)
   );

   // ---------------- clock / reset ----------------
   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   // ---------------- vector table ----------------
   typedef struct {
      logic          clr;
      logic          wr;
      logic          rd;
      logic [DW-1:0] din;
      logic [DW-1:0] e_dout;
      logic [AW:0]   e_cnt;
      logic          e_empty;
      logic          e_full;
      logic          e_ae;
      logic          e_af;
      logic          e_ovf;
      logic          e_udf;
   } vec_t;

   localparam int NV = 26;
   vec_t vecs [NV];

   // ---------------- driver tasks ----------------
   task automatic s_step(input logic c, input logic w, input logic r, input logic [DW-1:0] d);
      s_clear = c; s_wr = w; s_rd = r; s_din = d;
      @(posedge sys_clk);
      #1;
      s_clear = 1'b0; s_wr = 1'b0; s_rd = 1'b0;
   endtask

   task automatic f_step(input logic c, input logic w, input logic r, input logic [DW-1:0] d);
      f_clear = c; f_wr = w; f_rd = r; f_din = d;
      @(posedge sys_clk);
      #1;
      f_clear = 1'b0; f_wr = 1'b0; f_rd = 1'b0;
   endtask

   // ---------------- scoreboard compare ----------------
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] s_pack();
      return 64'({s_dout, s_cnt, s_empty, s_full, s_ae, s_af, s_ovf, s_udf});
   endfunction

   function automatic logic [63:0] v_pack(input vec_t v);
      return 64'({v.e_dout, v.e_cnt, v.e_empty, v.e_full, v.e_ae, v.e_af, v.e_ovf, v.e_udf});
   endfunction

   // ---------------- stimulus ----------------
   initial begin
      n_vec = 0;
      n_err = 0;

      //          clr  wr   rd   din     dout    cnt  emp  ful  ae   af   ovf  udf
      vecs[0]  = '{1'b0,1'b1,1'b0,16'd1,  16'd0,  4'd1,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0};
      vecs[1]  = '{1'b0,1'b1,1'b0,16'd2,  16'd0,  4'd2,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
      vecs[2]  = '{1'b0,1'b1,1'b0,16'd3,  16'd0,  4'd3,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
      vecs[3]  = '{1'b0,1'b1,1'b0,16'd4,  16'd0,  4'd4,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
      vecs[4]  = '{1'b0,1'b1,1'b0,16'd5,  16'd0,  4'd5,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
      vecs[5]  = '{1'b0,1'b1,1'b0,16'd6,  16'd0,  4'd6,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0};
      vecs[6]  = '{1'b0,1'b1,1'b0,16'd7,  16'd0,  4'd7,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0};
      vecs[7]  = '{1'b0,1'b1,1'b0,16'd8,  16'd0,  4'd8,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0};
      vecs[8]  = '{1'b0,1'b1,1'b0,16'd9,  16'd0,  4'd8,1'b0,1'b1,1'b0,1'b1,1'b1,1'b0};
      vecs[9]  = '{1'b0,1'b0,1'b0,16'd0,  16'd0,  4'd8,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0};
      vecs[10] = '{1'b0,1'b1,1'b1,16'd9,  16'd1,  4'd7,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0};
      vecs[11] = '{1'b0,1'b0,1'b1,16'd0,  16'd2,  4'd6,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0};
      vecs[12] = '{1'b0,1'b0,1'b1,16'd0,  16'd3,  4'd5,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
      vecs[13] = '{1'b0,1'b1,1'b1,16'd10, 16'd4,  4'd5,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
      vecs[14] = '{1'b0,1'b0,1'b1,16'd0,  16'd5,  4'd4,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
      vecs[15] = '{1'b0,1'b0,1'b1,16'd0,  16'd6,  4'd3,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
      vecs[16] = '{1'b0,1'b0,1'b1,16'd0,  16'd7,  4'd2,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
      vecs[17] = '{1'b0,1'b0,1'b1,16'd0,  16'd8,  4'd1,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0};
      vecs[18] = '{1'b0,1'b0,1'b1,16'd0,  16'd10, 4'd0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0};
      vecs[19] = '{1'b0,1'b0,1'b1,16'd0,  16'd10, 4'd0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b1};
      vecs[20] = '{1'b0,1'b1,1'b1,16'd11, 16'd10, 4'd1,1'b0,1'b0,1'b1,1'b0,1'b0,1'b1};
      vecs[21] = '{1'b0,1'b0,1'b1,16'd0,  16'd11, 4'd0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0};
      vecs[22] = '{1'b0,1'b1,1'b0,16'd12, 16'd11, 4'd1,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0};
      vecs[23] = '{1'b0,1'b1,1'b0,16'd13, 16'd11, 4'd2,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
      vecs[24] = '{1'b1,1'b1,1'b1,16'd14, 16'd0,  4'd0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0};
      vecs[25] = '{1'b0,1'b0,1'b1,16'd0,  16'd0,  4'd0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b1};

      s_clear = 1'b0; s_wr = 1'b0; s_rd = 1'b0; s_din = '0;
      f_clear = 1'b0; f_wr = 1'b0; f_rd = 1'b0; f_din = '0;
      sys_rst_n = 1'b0;
      repeat (2) @(posedge sys_clk);
      #1;
      chk("reset_std", s_pack(), 64'({16'd0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}));
      chk("reset_fwft", 64'({f_cnt, f_empty, f_full, f_ae, f_af, f_ovf, f_udf}),
          64'({4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}));
      @(negedge sys_clk);
      sys_rst_n = 1'b1;
      @(posedge sys_clk);
      #1;

      // Table: fill, overflow, full wr+rd, drain with thresholds, empty wr+rd, clear
      for (int i = 0; i < NV; i++) begin
         s_step(vecs[i].clr, vecs[i].wr, vecs[i].rd, vecs[i].din);
         chk($sformatf("vec%0d", i), s_pack(), v_pack(vecs[i]));
      end

      // Wrap: pointers start at 0 after the clear; 5 in/out then 8 in/out crosses the end
      for (int pass = 0; pass < 2; pass++) begin
         int n;
         n = (pass == 0) ? 5 : 8;
         for (int i = 0; i < n; i++) begin
            logic [DW-1:0] d;
            d = DW'(16'h1100 + 16'(pass * 16'h100) + 16'(i));
            exp_q.push_back(d);
            s_step(1'b0, 1'b1, 1'b0, d);
         end
         chk($sformatf("wrap_cnt%0d", pass), 64'(s_cnt), 64'(n));
         for (int i = 0; i < n; i++) begin
            logic [DW-1:0] e;
            e = exp_q.pop_front();
            s_step(1'b0, 1'b0, 1'b1, '0);
            chk($sformatf("wrap%0d_rd%0d", pass, i), 64'(s_dout), 64'(e));
         end
         chk($sformatf("wrap_empty%0d", pass), 64'({s_empty, s_cnt}), 64'({1'b1, 4'd0}));
      end

      // Async reset in the middle of a burst: outputs collapse without a clock edge
      s_step(1'b0, 1'b1, 1'b0, 16'h00AA);
      s_step(1'b0, 1'b1, 1'b0, 16'h00BB);
      s_step(1'b0, 1'b1, 1'b1, 16'h00CC);
      chk("burst_pre", s_pack(), 64'({16'h00AA, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}));
      #2;
      sys_rst_n = 1'b0;
      #1;
      chk("async_reset", s_pack(), 64'({16'd0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}));
      @(negedge sys_clk);
      sys_rst_n = 1'b1;
      @(posedge sys_clk);
      #1;

      // FWFT: head word visible as soon as empty falls, pop shows next word
      f_step(1'b0, 1'b1, 1'b0, 16'hA5A5);
      chk("fwft_first", 64'({f_dout, f_empty, f_cnt}), 64'({16'hA5A5, 1'b0, 4'd1}));
      f_step(1'b0, 1'b1, 1'b0, 16'h0002);
      f_step(1'b0, 1'b1, 1'b0, 16'h0003);
      chk("fwft_cnt3", 64'({f_dout, f_cnt}), 64'({16'hA5A5, 4'd3}));
      f_step(1'b0, 1'b1, 1'b1, 16'h0004);
      chk("fwft_pop", 64'({f_dout, f_cnt}), 64'({16'h0002, 4'd3}));
      f_step(1'b1, 1'b1, 1'b0, 16'h0005);
      chk("fwft_clear", 64'({f_empty, f_cnt, f_ovf, f_udf}), 64'({1'b1, 4'd0, 1'b0, 1'b0}));
      f_step(1'b0, 1'b0, 1'b0, '0);
      chk("fwft_clear_drop", 64'({f_empty, f_cnt}), 64'({1'b1, 4'd0}));
      f_step(1'b0, 1'b1, 1'b0, 16'h0006);
      chk("fwft_after_clear", 64'({f_dout, f_empty, f_cnt}), 64'({16'h0006, 1'b0, 4'd1}));
      f_step(1'b0, 1'b0, 1'b1, '0);
      chk("fwft_drain", 64'({f_empty, f_ae, f_cnt}), 64'({1'b1, 1'b1, 4'd0}));

      // ---------------- final report ----------------
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
